// File: rtl/led_scan_driver_if.sv
// Bus bundle for the multiplexed 7-segment driver: BCD value, overflow, load strobe,
// zero-suppression enable, and the active-low anode/cathode lines.
interface led_scan_driver_if;
    logic [15:0] num;
    logic        ovf;
    logic        load;
    logic        lz_blank;
    logic [3:0]  anodes;
    logic [7:0]  cathodes;

    modport master (
        output num,
        output ovf,
        output load,
        output lz_blank,
        input  anodes,
        input  cathodes
    );

    modport slave (
        input  num,
        input  ovf,
        input  load,
        input  lz_blank,
        output anodes,
        output cathodes
    );
endinterface

// File: rtl/led_scan_driver.sv
// Four-digit multiplexed 7-segment driver with internal scan prescaler, ghost blanking,
// leading-zero suppression and an overflow dash pattern. Outputs are registered.
module led_scan_driver #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 17
) (
    input  logic               clk,
    input  logic               reset_n,
    led_scan_driver_if.slave   bus
);

    logic [CNT_W-1:0] p_q, p_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      disp_q, disp_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       anodes_q, anodes_d;
    logic [7:0]       cathodes_q, cathodes_d;

    logic [3:0]       digit;
    logic             lead_zero;

    // Segment pattern {dp,g,f,e,d,c,b,a}, active low; non-BCD codes show a dash.
    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hBF;
        endcase
        return s;
    endfunction

    always_comb begin
        p_d        = p_q + 1'b1;
        idx_d      = idx_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        anodes_d   = 4'hF;
        cathodes_d = 8'hFF;
        digit      = disp_q[{idx_q, 2'b00} +: 4];
        lead_zero  = 1'b0;

        if (p_q == CNT_W'(SCAN_DIV - 1)) begin
            p_d   = '0;
            idx_d = idx_q + 2'd1;
        end

        if (bus.load) begin
            disp_d = bus.num;
            ovf_d  = bus.ovf;
        end

        // A slot is dark when its digit and every more-significant digit are zero.
        case (idx_q)
            2'd1:    lead_zero = (disp_q[15:4] == 12'h000);
            2'd2:    lead_zero = (disp_q[15:8] == 8'h00);
            2'd3:    lead_zero = (disp_q[15:12] == 4'h0);
            default: lead_zero = 1'b0;
        endcase

        if (p_q >= CNT_W'(BLANK_CYCLES)) begin
            if (ovf_q) begin
                anodes_d   = ~(4'b0001 << idx_q);
                cathodes_d = 8'hBF;
            end else if (!(bus.lz_blank && lead_zero)) begin
                anodes_d   = ~(4'b0001 << idx_q);
                cathodes_d = seg7(digit);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q        <= '0;
            idx_q      <= 2'd0;
            disp_q     <= 16'h0000;
            ovf_q      <= 1'b0;
            anodes_q   <= 4'hF;
            cathodes_q <= 8'hFF;
        end else begin
            p_q        <= p_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            anodes_q   <= anodes_d;
            cathodes_q <= cathodes_d;
        end
    end

    assign bus.anodes   = anodes_q;
    assign bus.cathodes = cathodes_q;

endmodule
